// File: rtl/csh_pkg.sv
// CSH cache cycle sequencer: shared types and constants.
// States, requester bit positions and the one-hot grant type.
package csh_pkg;

    typedef enum logic [2:0] {
        IDLE,
        T_RUN,
        MEMRQ,
        MEMWT,
        FILL
    } csh_state_t;

    localparam int REQ_EBOX = 0;
    localparam int REQ_CHAN = 1;
    localparam int REQ_MB   = 2;
    localparam int REQ_CCA  = 3;

    localparam int SWEEP_AW = 7;

    typedef logic [3:0] grant_t;

endpackage

// File: rtl/csh_cyc_sequencer_if.sv
// CSH sequencer request/status bundle.
// master drives requests and memory status; slave is the sequencer.
interface csh_cyc_sequencer_if;
    import csh_pkg::*;

    logic                ebox_req_h;
    logic                ebox_cyc_abort_h;
    logic                chan_req_h;
    logic                mb_req_h;
    logic                cca_req_h;
    logic                any_valid_match_h;
    logic                core_busy_h;
    logic                core_data_valid_h;
    grant_t              grant_h;
    logic [2:0]          t_phase_h;
    logic                core_rd_rq_h;
    logic                cyc_done_h;
    logic                ready_to_go_h;
    logic                mem_tmo_h;
    logic [SWEEP_AW-1:0] sweep_adr_h;
    logic                sweep_done_h;

    modport master (
        output ebox_req_h, ebox_cyc_abort_h, chan_req_h, mb_req_h,
        output cca_req_h, any_valid_match_h, core_busy_h,
        output core_data_valid_h,
        input  grant_h, t_phase_h, core_rd_rq_h, cyc_done_h,
        input  ready_to_go_h, mem_tmo_h, sweep_adr_h, sweep_done_h
    );

    modport slave (
        input  ebox_req_h, ebox_cyc_abort_h, chan_req_h, mb_req_h,
        input  cca_req_h, any_valid_match_h, core_busy_h,
        input  core_data_valid_h,
        output grant_h, t_phase_h, core_rd_rq_h, cyc_done_h,
        output ready_to_go_h, mem_tmo_h, sweep_adr_h, sweep_done_h
    );

endinterface

// File: rtl/csh_cyc_prio_enc.sv
// Fixed-priority requester encoder: chan > mb > cca > ebox.
// Produces a one-hot grant, all zero when nothing requests.
module csh_cyc_prio_enc
    import csh_pkg::*;
(
    input  grant_t req,
    output grant_t gnt
);

    // Pick the highest-priority active requester
    always_comb begin
        gnt = '0;
        if (req[REQ_CHAN])
            gnt[REQ_CHAN] = 1'b1;
        else if (req[REQ_MB])
            gnt[REQ_MB] = 1'b1;
        else if (req[REQ_CCA])
            gnt[REQ_CCA] = 1'b1;
        else if (req[REQ_EBOX])
            gnt[REQ_EBOX] = 1'b1;
    end

endmodule

// File: rtl/csh_cyc_sequencer.sv
// CSH cache cycle arbiter/sequencer: grant, T-phases, miss fill.
// Define CSH_CCA_SWEEP_EN to enable CCA grants and the sweep counter.
module csh_cyc_sequencer
    import csh_pkg::*;
#(
    parameter int T_LAST      = 3,
    parameter int MEM_TMO     = 64,
    parameter int SWEEP_LINES = 128
)
(
    input logic clk_csh_h,
    input logic mr_reset_l,
    csh_cyc_sequencer_if.slave bus
);

    localparam int TW = $clog2(MEM_TMO);

`ifdef CSH_CCA_SWEEP_EN
    localparam bit CCA_EN = 1'b1;
`else
    localparam bit CCA_EN = 1'b0;
`endif

    csh_state_t    state;
    logic [2:0]    phase;
    grant_t        grant;
    logic [TW-1:0] tmo_cnt;
    logic          tmo;

    grant_t req_vec;
    grant_t enc_gnt;
    logic   ready;
    logic   abort_ok;
    logic   miss_go;
    logic   hit_end;
    logic   tmo_hit;

    assign req_vec = {bus.cca_req_h & CCA_EN, bus.mb_req_h,
                      bus.chan_req_h, bus.ebox_req_h};

    csh_cyc_prio_enc u_enc (
        .req (req_vec),
        .gnt (enc_gnt)
    );

    // Reset is folded in so every output reads 0 while it is held
    assign ready = mr_reset_l && state == IDLE && !bus.core_busy_h;

    assign abort_ok = state == T_RUN && grant[REQ_EBOX]
                   && phase <= 3'd1 && bus.ebox_cyc_abort_h;

    // Only ebox and chan cycles can miss; mb/cca always run to T_LAST
    assign miss_go = state == T_RUN && phase == 3'd1 && !abort_ok
                  && !bus.any_valid_match_h
                  && (grant[REQ_EBOX] || grant[REQ_CHAN]);

    assign hit_end = state == T_RUN && phase == 3'(T_LAST)
                  && !abort_ok && !miss_go;

    // Data arriving on the final wait clock beats the timeout
    assign tmo_hit = state == MEMWT && !bus.core_data_valid_h
                  && tmo_cnt == TW'(MEM_TMO - 1);

    assign bus.grant_h       = grant;
    assign bus.t_phase_h     = phase;
    assign bus.core_rd_rq_h  = state == MEMRQ && !bus.core_busy_h;
    assign bus.cyc_done_h    = hit_end || state == FILL || tmo_hit;
    assign bus.ready_to_go_h = ready;
    assign bus.mem_tmo_h     = tmo;

    // Cycle state machine with phase and memory-timeout counters
    always_ff @(posedge clk_csh_h) begin
        if (!mr_reset_l) begin
            state   <= IDLE;
            phase   <= '0;
            grant   <= '0;
            tmo_cnt <= '0;
            tmo     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ready && req_vec != '0) begin
                        state <= T_RUN;
                        grant <= enc_gnt;
                        phase <= '0;
                    end
                end
                T_RUN: begin
                    if (abort_ok || hit_end) begin
                        state <= IDLE;
                        grant <= '0;
                        phase <= '0;
                    end else if (miss_go) begin
                        state <= MEMRQ;
                    end else begin
                        phase <= phase + 3'd1;
                    end
                end
                MEMRQ: begin
                    if (!bus.core_busy_h) begin
                        state   <= MEMWT;
                        tmo_cnt <= '0;
                    end
                end
                MEMWT: begin
                    if (bus.core_data_valid_h) begin
                        state <= FILL;
                    end else if (tmo_hit) begin
                        tmo   <= 1'b1;
                        state <= IDLE;
                        grant <= '0;
                        phase <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                FILL: begin
                    state <= IDLE;
                    grant <= '0;
                    phase <= '0;
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                    phase <= '0;
                end
            endcase
        end
    end

`ifdef CSH_CCA_SWEEP_EN
    localparam logic [SWEEP_AW-1:0] SW_LAST = SWEEP_AW'(SWEEP_LINES - 1);

    logic [SWEEP_AW-1:0] sweep_adr;
    logic                cca_end;

    assign cca_end          = hit_end && grant[REQ_CCA];
    assign bus.sweep_adr_h  = sweep_adr;
    assign bus.sweep_done_h = cca_end && sweep_adr == SW_LAST;

    // Advance the swept line in the last clock of each CCA cycle
    always_ff @(posedge clk_csh_h) begin
        if (!mr_reset_l)
            sweep_adr <= '0;
        else if (cca_end)
            sweep_adr <= (sweep_adr == SW_LAST) ? '0
                       : sweep_adr + SWEEP_AW'(1);
    end
`else
    assign bus.sweep_adr_h  = '0;
    assign bus.sweep_done_h = 1'b0;
`endif

endmodule

// File: tb/tb_csh_cyc_sequencer.sv
// Self-checking bench for csh_cyc_sequencer.
// Vector table plus hand sequences; cycle-end scoreboard on grant.
module tb_csh_cyc_sequencer;

    logic clk = 1'b0;
    logic rst_l;

    always #5 clk = ~clk;

    csh_cyc_sequencer_if bus();

    csh_cyc_sequencer dut (
        .clk_csh_h  (clk),
        .mr_reset_l (rst_l),
        .bus        (bus)
    );

    typedef struct {
        logic [3:0] req;
        logic       match;
        logic [3:0] grant;
    } vec_t;

    vec_t       tbl [6];
    logic [3:0] exp_q [$];
    int         chk_cnt = 0;
    int         pass_cnt = 0;
    int         rd_cnt = 0;
    int         sd_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        chk_cnt++;
        if (act === exp)
            pass_cnt++;
        else
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [3:0] r);
        bus.ebox_req_h = r[0];
        bus.chan_req_h = r[1];
        bus.mb_req_h   = r[2];
        bus.cca_req_h  = r[3];
    endtask

    task automatic wait_grant(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.grant_h != 4'b0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("grant_wait_expired", 32'd0, 32'd1);
    endtask

    task automatic run_hit(input logic [3:0] r, input logic [3:0] g);
        bit ok;
        int rd0;
        rd0 = rd_cnt;
        set_req(r);
        exp_q.push_back(g);
        wait_grant(ok);
        set_req(4'b0);
        if (!ok) begin
            exp_q.delete();
            return;
        end
        for (int k = 0; k <= 3; k++) begin
            chk("hit_phase", 32'(bus.t_phase_h), k);
            chk("hit_grant", 32'(bus.grant_h), 32'(g));
            tick();
        end
        chk("hit_idle_grant", 32'(bus.grant_h), 32'd0);
        chk("hit_idle_phase", 32'(bus.t_phase_h), 32'd0);
        chk("hit_no_rd_rq", rd_cnt, rd0);
    endtask

    // Scoreboard: every cycle end pops the grant it must carry
    always @(negedge clk) begin
        if (bus.core_rd_rq_h) rd_cnt++;
        if (bus.sweep_done_h) begin
            sd_cnt++;
            if (!bus.cyc_done_h) chk("sweep_done_w_cyc", 32'd0, 32'd1);
        end
        if (bus.cyc_done_h) begin
            if (exp_q.size() == 0)
                chk("unexpected_done", 32'd1, 32'd0);
            else
                chk("done_grant", 32'(bus.grant_h), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        bit ok;
        int n;
        int rd0;
        logic [3:0] ord [3];
        logic [3:0] cur;

        tbl[0] = '{4'b0001, 1'b1, 4'b0001};
        tbl[1] = '{4'b0010, 1'b1, 4'b0010};
        tbl[2] = '{4'b0100, 1'b1, 4'b0100};
        tbl[3] = '{4'b0100, 1'b0, 4'b0100};
        tbl[4] = '{4'b0011, 1'b1, 4'b0010};
        tbl[5] = '{4'b0101, 1'b0, 4'b0100};

        rst_l = 1'b0;
        set_req(4'b0);
        bus.ebox_cyc_abort_h  = 1'b0;
        bus.any_valid_match_h = 1'b1;
        bus.core_busy_h       = 1'b0;
        bus.core_data_valid_h = 1'b0;
        repeat (2) tick();
        chk("rst_grant", 32'(bus.grant_h), 32'd0);
        chk("rst_phase", 32'(bus.t_phase_h), 32'd0);
        chk("rst_ready", 32'(bus.ready_to_go_h), 32'd0);
        chk("rst_tmo", 32'(bus.mem_tmo_h), 32'd0);
        chk("rst_sweep", 32'(bus.sweep_adr_h), 32'd0);
        rst_l = 1'b1;
        tick();
        chk("ready_after_rst", 32'(bus.ready_to_go_h), 32'd1);

        for (int i = 0; i < 6; i++) begin
            bus.any_valid_match_h = tbl[i].match;
            run_hit(tbl[i].req, tbl[i].grant);
        end
        bus.any_valid_match_h = 1'b1;

        // Busy memory holds off a pending request
        bus.core_busy_h = 1'b1;
        set_req(4'b0001);
        #1;
        chk("busy_not_ready", 32'(bus.ready_to_go_h), 32'd0);
        repeat (3) begin
            tick();
            chk("busy_no_grant", 32'(bus.grant_h), 32'd0);
        end
        bus.core_busy_h = 1'b0;
        run_hit(4'b0001, 4'b0001);

        // chan+mb+ebox together: chan, mb, ebox with one idle clock each
        ord[0] = 4'b0010;
        ord[1] = 4'b0100;
        ord[2] = 4'b0001;
        cur = 4'b0111;
        set_req(cur);
        for (int j = 0; j < 3; j++) exp_q.push_back(ord[j]);
        wait_grant(ok);
        for (int j = 0; j < 3; j++) begin
            chk("prio_grant", 32'(bus.grant_h), 32'(ord[j]));
            cur = cur & ~ord[j];
            set_req(cur);
            repeat (4) tick();
            chk("prio_idle", 32'(bus.grant_h), 32'd0);
            if (j < 2) tick();
        end
        exp_q.delete();

        // ebox miss, memory busy 3 clocks, data after 10 wait clocks
        bus.any_valid_match_h = 1'b0;
        rd0 = rd_cnt;
        set_req(4'b0001);
        exp_q.push_back(4'b0001);
        wait_grant(ok);
        set_req(4'b0);
        bus.core_busy_h = 1'b1;
        repeat (2) tick();
        for (int i = 0; i < 3; i++) begin
            chk("miss_rd_held", 32'(bus.core_rd_rq_h), 32'd0);
            tick();
        end
        bus.core_busy_h = 1'b0;
        #1;
        chk("miss_rd_rq", 32'(bus.core_rd_rq_h), 32'd1);
        tick();
        chk("miss_rd_once", 32'(bus.core_rd_rq_h), 32'd0);
        repeat (9) begin
            chk("miss_wait_done", 32'(bus.cyc_done_h), 32'd0);
            tick();
        end
        bus.core_data_valid_h = 1'b1;
        tick();
        bus.core_data_valid_h = 1'b0;
        chk("fill_done", 32'(bus.cyc_done_h), 32'd1);
        chk("fill_grant", 32'(bus.grant_h), 32'd1);
        tick();
        chk("fill_idle", 32'(bus.grant_h), 32'd0);
        chk("miss_rd_count", rd_cnt, rd0 + 1);

        // chan miss with no data: timeout after 64 wait clocks
        set_req(4'b0010);
        exp_q.push_back(4'b0010);
        wait_grant(ok);
        set_req(4'b0);
        repeat (3) tick();
        n = 1;
        while (!bus.cyc_done_h && n < 100) begin
            tick();
            n++;
        end
        chk("tmo_clocks", n, 64);
        chk("tmo_not_yet", 32'(bus.mem_tmo_h), 32'd0);
        tick();
        chk("tmo_set", 32'(bus.mem_tmo_h), 32'd1);
        chk("tmo_idle", 32'(bus.grant_h), 32'd0);
        bus.any_valid_match_h = 1'b1;
        run_hit(4'b0001, 4'b0001);
        chk("tmo_sticky", 32'(bus.mem_tmo_h), 32'd1);
        rst_l = 1'b0;
        tick();
        rst_l = 1'b1;
        chk("tmo_cleared", 32'(bus.mem_tmo_h), 32'd0);
        tick();

        // ebox abort at T1 ends the cycle with no cyc_done
        set_req(4'b0001);
        wait_grant(ok);
        set_req(4'b0);
        tick();
        chk("abort_t1", 32'(bus.t_phase_h), 32'd1);
        bus.ebox_cyc_abort_h = 1'b1;
        tick();
        chk("abort_idle", 32'(bus.grant_h), 32'd0);
        chk("abort_phase", 32'(bus.t_phase_h), 32'd0);
        tick();
        // Abort has no effect on a chan cycle
        run_hit(4'b0010, 4'b0010);
        bus.ebox_cyc_abort_h = 1'b0;

        // Reset in the middle of MEMWT
        bus.any_valid_match_h = 1'b0;
        set_req(4'b0001);
        exp_q.push_back(4'b0001);
        wait_grant(ok);
        set_req(4'b0);
        repeat (5) tick();
        exp_q.delete();
        rst_l = 1'b0;
        tick();
        chk("mrst_grant", 32'(bus.grant_h), 32'd0);
        chk("mrst_phase", 32'(bus.t_phase_h), 32'd0);
        chk("mrst_done", 32'(bus.cyc_done_h), 32'd0);
        chk("mrst_rd", 32'(bus.core_rd_rq_h), 32'd0);
        chk("mrst_ready", 32'(bus.ready_to_go_h), 32'd0);
        rst_l = 1'b1;
        bus.any_valid_match_h = 1'b1;
        tick();
        chk("mrst_ready_back", 32'(bus.ready_to_go_h), 32'd1);

`ifdef CSH_CCA_SWEEP_EN
        for (int i = 0; i < 128; i++) begin
            chk("sweep_adr", 32'(bus.sweep_adr_h), i);
            run_hit(4'b1000, 4'b1000);
        end
        chk("sweep_wrap", 32'(bus.sweep_adr_h), 32'd0);
        chk("sweep_done_cnt", sd_cnt, 1);
`else
        set_req(4'b1000);
        repeat (5) begin
            tick();
            chk("cca_no_grant", 32'(bus.grant_h), 32'd0);
        end
        set_req(4'b0);
        chk("cca_adr_tied", 32'(bus.sweep_adr_h), 32'd0);
        chk("cca_done_tied", sd_cnt, 0);
`endif

        repeat (2) tick();
        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
